// File: rtl/vp_color_pkg.sv
// ============================================================================
// Module      : vp_color_pkg
// Description : Shared colour-space constants: mode encodings, BT.601/BT.709
//               studio-range coefficient sets and offsets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vp_color_pkg;

    typedef enum logic [1:0] {
        MODE_BT601  = 2'b00,
        MODE_BT709  = 2'b01,
        MODE_BYPASS = 2'b10,
        MODE_RSVD   = 2'b11
    } csc_mode_e;

    localparam int c_coef_frac_ref = 12;

    // Row order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
    localparam int c_bt601_q12 [9] = '{ 1053,  2064,   401,
                                        -606, -1192,  1798,
                                        1798, -1507,  -291};
    localparam int c_bt709_q12 [9] = '{  750,  2515,   254,
                                        -414, -1389,  1798,
                                        1798, -1634,  -164};

    // Source real coefficients in thousandths, used when FRAC_W differs from 12
    localparam int c_bt601_milli [9] = '{ 257,  504,   98,
                                         -148, -291,  439,
                                          439, -368,  -71};
    localparam int c_bt709_milli [9] = '{ 183,  614,   62,
                                         -101, -339,  439,
                                          439, -399,  -40};

    localparam int c_offset_y_8 = 16;
    localparam int c_offset_c_8 = 128;

    function automatic int coef_scale(input int q12, input int milli, input int frac);
        longint mag;
        if (frac == c_coef_frac_ref) begin
            return q12;
        end
        mag = (milli < 0) ? -longint'(milli) : longint'(milli);
        mag = (mag * (longint'(1) << frac) * 2 + 1000) / 2000;
        return (milli < 0) ? -int'(mag) : int'(mag);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csc_sat.sv
// ============================================================================
// Module      : csc_sat
// Description : Signed accumulator -> floor shift by FRAC_W -> clamp to PIX_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csc_sat #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 12,
    parameter int ACC_W  = PIX_W + FRAC_W + 3
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [PIX_W-1:0] o_pix
);

    localparam logic signed [ACC_W-1:0] c_max = ACC_W'((longint'(1) << PIX_W) - 1);

    logic signed [ACC_W-1:0] w_shift;

    assign w_shift = i_acc >>> FRAC_W;

    always_comb begin
        o_pix = w_shift[PIX_W-1:0];
        if (w_shift[ACC_W-1]) begin
            o_pix = '0;
        end else if (w_shift > c_max) begin
            o_pix = {PIX_W{1'b1}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/rgb2ycbcr_pipe.sv
// ============================================================================
// Module      : rgb2ycbcr_pipe
// Description : Pipelined RGB->YCbCr converter (BT.601/BT.709/bypass per pixel)
//               with valid/ready backpressure and sideband pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb2ycbcr_pipe
    import vp_color_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 12,
    parameter int USER_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_red,
    input  logic [PIX_W-1:0]  in_green,
    input  logic [PIX_W-1:0]  in_blue,
    input  logic [USER_W-1:0] in_user,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_y,
    output logic [PIX_W-1:0]  out_cb,
    output logic [PIX_W-1:0]  out_cr,
    output logic [USER_W-1:0] out_user
);

    localparam int c_acc_w  = PIX_W + FRAC_W + 3;
    localparam int c_coef_w = FRAC_W + 2;

    localparam logic signed [c_acc_w-1:0] c_off_y =
        c_acc_w'(longint'(c_offset_y_8) << (PIX_W - 8 + FRAC_W));
    localparam logic signed [c_acc_w-1:0] c_off_c =
        c_acc_w'(longint'(c_offset_c_8) << (PIX_W - 8 + FRAC_W));
    localparam logic signed [c_acc_w-1:0] c_round =
        c_acc_w'(longint'(1) << (FRAC_W - 1));

    // Input sample stage
    logic                r_s0_valid;
    logic [PIX_W-1:0]    r_s0_comp [3];
    logic [USER_W-1:0]   r_s0_user;
    csc_mode_e           r_s0_mode;

    // S1: products
    logic                      r_s1_valid;
    logic signed [c_acc_w-1:0] r_s1_prod [9];
    logic [USER_W-1:0]         r_s1_user;
    csc_mode_e                 r_s1_mode;

    // S2: accumulators
    logic                      r_s2_valid;
    logic signed [c_acc_w-1:0] r_s2_acc [3];
    logic [USER_W-1:0]         r_s2_user;

    logic                       w_adv;
    csc_mode_e                  w_in_mode;
    logic signed [c_coef_w-1:0] w_coef [9];
    logic signed [c_acc_w-1:0]  w_prod [9];
    logic signed [c_acc_w-1:0]  w_sum  [3];
    logic [PIX_W-1:0]           w_pix  [3];

    // A stalled output freezes every stage, so one enable drives the whole pipe
    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign w_in_mode = (in_mode == MODE_RSVD) ? MODE_BT601 : csc_mode_e'(in_mode);

    // Bypass is a unity-gain permutation: Y<-G, Cb<-B, Cr<-R with no offset
    generate
        for (genvar i = 0; i < 9; i++) begin : g_coef
            localparam int c_k601 = coef_scale(c_bt601_q12[i], c_bt601_milli[i], FRAC_W);
            localparam int c_k709 = coef_scale(c_bt709_q12[i], c_bt709_milli[i], FRAC_W);
            localparam int c_kbyp = (i == 1 || i == 5 || i == 6) ? (1 << FRAC_W) : 0;

            assign w_coef[i] = (r_s0_mode == MODE_BT709)  ? c_coef_w'(c_k709) :
                               (r_s0_mode == MODE_BYPASS) ? c_coef_w'(c_kbyp) :
                                                            c_coef_w'(c_k601);
            assign w_prod[i] = c_acc_w'(w_coef[i]) *
                               c_acc_w'($signed({1'b0, r_s0_comp[i % 3]}));
        end

        for (genvar c = 0; c < 3; c++) begin : g_chan
            logic signed [c_acc_w-1:0] w_off;

            assign w_off    = (r_s1_mode == MODE_BYPASS) ? '0 :
                              (c == 0) ? c_off_y : c_off_c;
            assign w_sum[c] = r_s1_prod[3*c] + r_s1_prod[3*c+1] + r_s1_prod[3*c+2]
                            + w_off + c_round;

            csc_sat #(
                .PIX_W  (PIX_W),
                .FRAC_W (FRAC_W),
                .ACC_W  (c_acc_w)
            ) u_sat (
                .i_acc (r_s2_acc[c]),
                .o_pix (w_pix[c])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_user  <= '0;
            r_s0_mode  <= MODE_BT601;
            r_s1_valid <= 1'b0;
            r_s1_user  <= '0;
            r_s1_mode  <= MODE_BT601;
            r_s2_valid <= 1'b0;
            r_s2_user  <= '0;
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_cb     <= '0;
            out_cr     <= '0;
            out_user   <= '0;
            for (int i = 0; i < 3; i++) begin
                r_s0_comp[i] <= '0;
                r_s2_acc[i]  <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                r_s1_prod[i] <= '0;
            end
        end else if (w_adv) begin
            r_s0_valid   <= in_valid;
            r_s0_comp[0] <= in_red;
            r_s0_comp[1] <= in_green;
            r_s0_comp[2] <= in_blue;
            r_s0_user    <= in_user;
            r_s0_mode    <= w_in_mode;

            r_s1_valid <= r_s0_valid;
            r_s1_user  <= r_s0_user;
            r_s1_mode  <= r_s0_mode;
            for (int i = 0; i < 9; i++) begin
                r_s1_prod[i] <= w_prod[i];
            end

            r_s2_valid <= r_s1_valid;
            r_s2_user  <= r_s1_user;
            for (int i = 0; i < 3; i++) begin
                r_s2_acc[i] <= w_sum[i];
            end

            out_valid <= r_s2_valid;
            out_y     <= w_pix[0];
            out_cb    <= w_pix[1];
            out_cr    <= w_pix[2];
            out_user  <= r_s2_user;
        end
    end

endmodule

`default_nettype wire
